// File: rtl/axi_sram_slv.sv
// AXI4-lite SRAM responder: independent read/write FSMs with programmable response latency.
// Optional feature macro AXI_SLV_RAND_DELAY_EN: LFSR-driven 1..4 cycle latencies instead of RD_LAT/WR_LAT.
module axi_sram_slv #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned       RD_LAT      = 2,
  parameter int unsigned       WR_LAT      = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                slv_ar_valid_i,
  input  logic [ADDR_W-1:0]   slv_ar_addr_i,
  output logic                slv_ar_ready_o,
  output logic                slv_r_valid_o,
  output logic [DATA_W-1:0]   slv_r_data_o,
  output logic [1:0]          slv_r_resp_o,
  input  logic                slv_r_ready_i,
  input  logic                slv_aw_valid_i,
  input  logic [ADDR_W-1:0]   slv_aw_addr_i,
  output logic                slv_aw_ready_o,
  input  logic                slv_w_valid_i,
  input  logic [DATA_W-1:0]   slv_w_data_i,
  input  logic [DATA_W/8-1:0] slv_w_strb_i,
  output logic                slv_w_ready_o,
  output logic                slv_b_valid_o,
  output logic [1:0]          slv_b_resp_o,
  input  logic                slv_b_ready_i
);
  localparam int unsigned     STRB_W = DATA_W / 8;
  localparam int unsigned     OFF_W  = $clog2(STRB_W);
  localparam int unsigned     IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] SPAN   = (ADDR_W+1)'(STRB_W * DEPTH_WORDS);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RSP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RSP} w_state_e;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> OFF_W);
  endfunction

  logic [7:0] rd_lat, wr_lat;
`ifdef AXI_SLV_RAND_DELAY_EN
  logic [3:0] lfsr_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= 4'b1001;
    else       lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end
  assign rd_lat = {6'd0, lfsr_q[1:0]} + 8'd1;
  assign wr_lat = rd_lat;
`else
  assign rd_lat = 8'(RD_LAT);
  assign wr_lat = 8'(WR_LAT);
`endif

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // ---------------- read path ----------------
  r_state_e          r_state_q;
  logic [7:0]        r_cnt_q;
  logic [ADDR_W-1:0] ar_addr_q, rd_addr;
  logic              ar_ready_q, r_valid_q, ar_hs, rd_load;
  logic [DATA_W-1:0] r_data_q;
  logic [1:0]        r_resp_q;

  // NOTE: readys are gated by rst_i so they drop the instant reset asserts, not at the next edge.
  assign slv_ar_ready_o = ar_ready_q & ~rst_i;
  assign slv_r_valid_o  = r_valid_q;
  assign slv_r_data_o   = r_data_q;
  assign slv_r_resp_o   = r_resp_q;
  assign ar_hs   = slv_ar_valid_i & slv_ar_ready_o;
  assign rd_addr = (r_state_q == R_IDLE) ? slv_ar_addr_i : ar_addr_q;
  assign rd_load = (ar_hs && rd_lat == 8'd0) || (r_state_q == R_WAIT && r_cnt_q == 8'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q  <= R_IDLE;
      r_cnt_q    <= '0;
      ar_addr_q  <= '0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: if (ar_hs) begin
          ar_ready_q <= 1'b0;
          ar_addr_q  <= slv_ar_addr_i;
          r_cnt_q    <= rd_lat;
          if (rd_lat != 8'd0) r_state_q <= R_WAIT;
        end
        R_WAIT: r_cnt_q <= r_cnt_q - 8'd1;
        R_RSP: if (slv_r_ready_i) begin
          r_state_q  <= R_IDLE;
          r_valid_q  <= 1'b0;
          ar_ready_q <= 1'b1;
        end
        default: r_state_q <= R_IDLE;
      endcase
      // Data is captured once on entry to R_RSP and held until the handshake.
      if (rd_load) begin
        r_state_q <= R_RSP;
        r_valid_q <= 1'b1;
        if (in_range(rd_addr)) begin
          r_data_q <= mem_q[word_idx(rd_addr)];
          r_resp_q <= RESP_OKAY;
        end else begin
          r_data_q <= '0;
          r_resp_q <= RESP_SLVERR;
        end
      end
    end
  end

  // ---------------- write path ----------------
  w_state_e          w_state_q;
  logic [7:0]        w_cnt_q;
  logic              aw_ready_q, w_ready_q, b_valid_q;
  logic [1:0]        b_resp_q;
  logic [ADDR_W-1:0] aw_addr_q, wr_addr;
  logic [DATA_W-1:0] w_data_q, wr_data;
  logic [STRB_W-1:0] w_strb_q, wr_strb;
  logic              aw_hs, w_hs, both_have, wr_commit;

  assign slv_aw_ready_o = aw_ready_q & ~rst_i;
  assign slv_w_ready_o  = w_ready_q & ~rst_i;
  assign slv_b_valid_o  = b_valid_q;
  assign slv_b_resp_o   = b_resp_q;
  assign aw_hs = slv_aw_valid_i & slv_aw_ready_o;
  assign w_hs  = slv_w_valid_i & slv_w_ready_o;
  // A channel still showing ready has not been captured, so its live inputs are the payload.
  assign wr_addr   = aw_ready_q ? slv_aw_addr_i : aw_addr_q;
  assign wr_data   = w_ready_q  ? slv_w_data_i  : w_data_q;
  assign wr_strb   = w_ready_q  ? slv_w_strb_i  : w_strb_q;
  assign both_have = (w_state_q == W_IDLE) && (~aw_ready_q | aw_hs) && (~w_ready_q | w_hs);
  assign wr_commit = (both_have && wr_lat == 8'd0) || (w_state_q == W_WAIT && w_cnt_q == 8'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q  <= W_IDLE;
      w_cnt_q    <= '0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_ready_q <= 1'b0;
            aw_addr_q  <= slv_aw_addr_i;
          end
          if (w_hs) begin
            w_ready_q <= 1'b0;
            w_data_q  <= slv_w_data_i;
            w_strb_q  <= slv_w_strb_i;
          end
          if (both_have) begin
            w_cnt_q <= wr_lat;
            if (wr_lat != 8'd0) w_state_q <= W_WAIT;
          end
        end
        W_WAIT: w_cnt_q <= w_cnt_q - 8'd1;
        W_RSP: if (slv_b_ready_i) begin
          w_state_q  <= W_IDLE;
          b_valid_q  <= 1'b0;
          aw_ready_q <= 1'b1;
          w_ready_q  <= 1'b1;
        end
        default: w_state_q <= W_IDLE;
      endcase
      if (wr_commit) begin
        w_state_q <= W_RSP;
        b_valid_q <= 1'b1;
        b_resp_q  <= in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // NOTE: the array has no reset so it maps onto plain SRAM; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (wr_commit && in_range(wr_addr)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem_q[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slv.sv
// Scoreboard bench for axi_sram_slv: directed corner cases plus randomized traffic against a byte-array model.
`timescale 1ns/1ps
module tb_axi_sram_slv;
  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 1024;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 2;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] ar_addr, r_data;
  logic [1:0]  r_resp, b_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;

  axi_sram_slv #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_ar_valid_i(ar_valid), .slv_ar_addr_i(ar_addr), .slv_ar_ready_o(ar_ready),
    .slv_r_valid_o(r_valid), .slv_r_data_o(r_data), .slv_r_resp_o(r_resp), .slv_r_ready_i(r_ready),
    .slv_aw_valid_i(aw_valid), .slv_aw_addr_i(aw_addr), .slv_aw_ready_o(aw_ready),
    .slv_w_valid_i(w_valid), .slv_w_data_i(w_data), .slv_w_strb_i(w_strb), .slv_w_ready_o(w_ready),
    .slv_b_valid_o(b_valid), .slv_b_resp_o(b_resp), .slv_b_ready_i(b_ready)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0, n_errors = 0, cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  typedef struct packed { logic [31:0] data; logic [1:0] resp; int exp_cyc; } r_exp_t;
  typedef struct packed { logic [1:0] resp; int exp_cyc; } b_exp_t;
  r_exp_t r_q[$];
  b_exp_t b_q[$];

  logic [7:0] mem_m [DEPTH][4];
  logic       r_stall = 1'b0, bp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed window, range test straight from the address map.
  function automatic bit m_in_range(input logic [31:0] a);
    longint unsigned la = a, lb = BASE;
    return (la >= lb) && (la < lb + 4 * DEPTH);
  endfunction
  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction
  function automatic logic [31:0] m_read(input logic [31:0] a);
    int i = m_idx(a);
    return {mem_m[i][3], mem_m[i][2], mem_m[i][1], mem_m[i][0]};
  endfunction

  // Ready generator: always ready unless stalled, random when backpressure is enabled.
  initial begin
    r_ready = 1'b0; b_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      r_ready = r_stall ? 1'b0 : (bp_en ? 1'($urandom_range(1)) : 1'b1);
      b_ready = bp_en ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // R monitor: pops on each new response, checks payload every cycle valid is up.
  initial begin
    r_exp_t cur;
    bit pend = 0, have = 0;
    forever begin
      @(negedge clk);
      if (rst) begin pend = 0; have = 0; end
      else begin
        if (pend) check("r_valid_held", r_valid, 1);
        if (r_valid) begin
          if (!pend) begin
            if (r_q.size() == 0) begin check("r_unexpected_valid", r_valid, 0); have = 0; end
            else begin
              cur = r_q.pop_front(); have = 1;
`ifndef AXI_SLV_RAND_DELAY_EN
              check("r_latency", cyc, cur.exp_cyc);
`endif
            end
          end
          if (have) begin
            check("r_data", r_data, cur.data);
            check("r_resp", r_resp, cur.resp);
          end
          pend = !r_ready;
        end else pend = 0;
      end
    end
  end

  // B monitor.
  initial begin
    b_exp_t cur;
    bit pend = 0, have = 0;
    forever begin
      @(negedge clk);
      if (rst) begin pend = 0; have = 0; end
      else begin
        if (pend) check("b_valid_held", b_valid, 1);
        if (b_valid) begin
          if (!pend) begin
            if (b_q.size() == 0) begin check("b_unexpected_valid", b_valid, 0); have = 0; end
            else begin
              cur = b_q.pop_front(); have = 1;
`ifndef AXI_SLV_RAND_DELAY_EN
              check("b_latency", cyc, cur.exp_cyc);
`endif
            end
          end
          if (have) check("b_resp", b_resp, cur.resp);
          pend = !b_ready;
        end else pend = 0;
      end
    end
  end

  task automatic do_read(input logic [31:0] addr);
    bit got = 0;
    r_exp_t e;
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_addr = addr;
    for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); if (ar_ready) got = 1; end
    check("ar_accept", got, 1);
    if (got) begin
      e.data    = m_in_range(addr) ? m_read(addr) : 32'h0;
      e.resp    = m_in_range(addr) ? 2'b00 : 2'b10;
      e.exp_cyc = cyc + 1 + RD_LAT;
      r_q.push_back(e);
    end
    @(posedge clk); #1;
    ar_valid = 1'b0; ar_addr = $urandom;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_pre, input int w_pre);
    bit aw_got = 0, w_got = 0;
    int aw_c = 0, w_c = 0;
    b_exp_t e;
    fork
      begin
        for (int i = 0; i < aw_pre; i++) begin
          @(negedge clk);
          if (w_got && cyc > w_c) check("w_ready_low_after_w", w_ready, 0);
        end
        @(posedge clk); #1;
        aw_valid = 1'b1; aw_addr = addr;
        for (int i = 0; i < 100 && !aw_got; i++) begin
          @(negedge clk); if (aw_ready) begin aw_got = 1; aw_c = cyc; end
        end
        @(posedge clk); #1;
        aw_valid = 1'b0; aw_addr = $urandom;
      end
      begin
        for (int i = 0; i < w_pre; i++) begin
          @(negedge clk);
          if (aw_got && cyc > aw_c) check("aw_ready_low_after_aw", aw_ready, 0);
        end
        @(posedge clk); #1;
        w_valid = 1'b1; w_data = data; w_strb = strb;
        for (int i = 0; i < 100 && !w_got; i++) begin
          @(negedge clk); if (w_ready) begin w_got = 1; w_c = cyc; end
        end
        @(posedge clk); #1;
        w_valid = 1'b0; w_data = $urandom; w_strb = 4'($urandom);
      end
    join
    check("aw_accept", aw_got, 1);
    check("w_accept", w_got, 1);
    if (aw_got && w_got) begin
      e.resp    = m_in_range(addr) ? 2'b00 : 2'b10;
      e.exp_cyc = ((aw_c > w_c) ? aw_c : w_c) + 1 + WR_LAT;
      b_q.push_back(e);
      if (m_in_range(addr))
        for (int b = 0; b < 4; b++) if (strb[b]) mem_m[m_idx(addr)][b] = data[8*b +: 8];
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (r_q.size() == 0) && (b_q.size() == 0) && !r_valid && !b_valid;
    end
    check("drain", done, 1);
  endtask

  task automatic wait_r_valid();
    for (int i = 0; i < 50 && !r_valid; i++) @(negedge clk);
    check("r_valid_seen", r_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    bit hs;
    ar_valid = 0; ar_addr = 0; aw_valid = 0; aw_addr = 0; w_valid = 0; w_data = 0; w_strb = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ar_ready", ar_ready, 0);
    check("rst_aw_ready", aw_ready, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_b_valid", b_valid, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_ar_ready", ar_ready, 1);
    check("post_rst_aw_ready", aw_ready, 1);
    check("post_rst_w_ready", w_ready, 1);
    check("post_rst_r_data", r_data, 0);
    check("post_rst_r_resp", r_resp, 0);
    check("post_rst_b_resp", b_resp, 0);

    // Fill the test window so every model word is known.
    for (int k = 0; k < 16; k++) begin do_write(BASE + 32'(4 * k), $urandom, 4'hF, 0, 0); drain(); end
    do_write(BASE + 32'hFFC, $urandom, 4'hF, 0, 0); drain();

    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0); drain();
    do_read(32'h8000_0010); drain();

    do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0); drain();
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, 0); drain();
    do_read(32'h8000_0020); drain();

    do_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF, 3, 0); drain();
    do_read(32'h8000_0030); drain();
    do_write(32'h8000_0034, 32'h0BAD_F00D, 4'hF, 0, 2); drain();
    do_read(32'h8000_0034); drain();

    do_read(32'h0000_1000); drain();
    do_write(32'h0000_1000, 32'h5555_AAAA, 4'hF, 0, 0); drain();
    do_write(BASE + 32'h1000, 32'h6666_9999, 4'hF, 0, 0); drain();
    do_write(BASE - 32'd4, 32'h7777_8888, 4'hF, 0, 0); drain();
    do_read(BASE); drain();
    do_read(BASE + 32'hFFC); drain();
    do_read(BASE + 32'h1000); drain();
    do_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'h0, 0, 0); drain();
    do_read(BASE + 32'hB); drain();

    // Read backpressure.
    r_stall = 1'b1;
    do_read(32'h8000_0010);
    wait_r_valid();
    repeat (5) begin @(negedge clk); check("bp_ar_ready_low", ar_ready, 0); end
    r_stall = 1'b0;
    hs = 0;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      if (r_valid && r_ready) begin hs = 1; check("bp_ar_ready_at_hs", ar_ready, 0); end
    end
    check("bp_handshake", hs, 1);
    @(negedge clk);
    check("bp_ar_ready_after_hs", ar_ready, 1);
    drain();

    // Asynchronous reset while a read response is pending.
    r_stall = 1'b1;
    do_read(BASE + 32'h4);
    wait_r_valid();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_r_valid", r_valid, 0);
    check("async_rst_ar_ready", ar_ready, 0);
    check("async_rst_aw_ready", aw_ready, 0);
    check("async_rst_w_ready", w_ready, 0);
    check("async_rst_b_valid", b_valid, 0);
    check("async_rst_r_data", r_data, 0);
    r_q.delete(); b_q.delete();
    r_stall = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    do_read(32'h8000_0010); drain();

    // Randomized traffic with random channel order and random response backpressure.
    bp_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      int sel = $urandom_range(0, 19);
      case (sel)
        16:      addr = BASE + 32'hFFC;
        17:      addr = BASE + 32'h1000;
        18:      addr = BASE - 32'd4;
        19:      addr = 32'h0000_1000;
        default: addr = BASE + 32'(4 * sel);
      endcase
      addr = addr + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) do_read(addr);
      else do_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      drain();
    end
    bp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
